// File: rtl/acc_register.sv
// Block accumulator: sums or subtracts a counted run of signed beats into a
// WIDTH-bit register, with wrap or saturate arithmetic and a sticky overflow flag.
module acc_register #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] d,
  input  logic             sub,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  typedef enum logic {IDLE, ACC} state_t;

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           st, st_nx;
  logic [WIDTH-1:0] acc, acc_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             ovf_r, ovf_nx;
  logic             done_r, done_nx;

  // One guard bit; overflow shows up as the top two bits disagreeing.
  logic [WIDTH:0]   a_x, d_x, res;
  logic             of;
  logic [WIDTH-1:0] res_w;

  always_comb begin
    a_x   = {acc[WIDTH-1], acc};
    d_x   = {d[WIDTH-1], d};
    res   = sub ? (a_x - d_x) : (a_x + d_x);
    of    = res[WIDTH] ^ res[WIDTH-1];
    res_w = res[WIDTH-1:0];
    if (SAT && of) res_w = res[WIDTH] ? SMIN : SMAX;
  end

  always_comb begin
    st_nx   = st;
    acc_nx  = acc;
    cnt_nx  = cnt;
    ovf_nx  = ovf_r;
    done_nx = 1'b0;
    if (start) begin
      acc_nx = '0;
      ovf_nx = 1'b0;
      cnt_nx = len;
      if (len != '0) begin
        st_nx = ACC;
      end else begin
        st_nx   = IDLE;
        done_nx = 1'b1;
      end
    end else if (st == ACC && in_valid) begin
      acc_nx = res_w;
      ovf_nx = ovf_r | of;
      cnt_nx = cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        st_nx   = IDLE;
        done_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st     <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      ovf_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      st     <= st_nx;
      acc    <= acc_nx;
      cnt    <= cnt_nx;
      ovf_r  <= ovf_nx;
      done_r <= done_nx;
    end
  end

  assign out  = acc;
  assign busy = (st == ACC);
  assign done = done_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_acc_register.sv
// Directed bench: a wrapping and a saturating instance share one stimulus stream.
module tb_acc_register;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] len;
  logic       in_valid;
  logic [7:0] d;
  logic       sub;

  logic [7:0] out0, out1;
  logic       busy0, busy1, done0, done1, ovf0, ovf1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  acc_register #(.WIDTH(8), .CNT_W(4), .SAT(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid),
    .d(d), .sub(sub), .out(out0), .busy(busy0), .done(done0), .ovf(ovf0));

  acc_register #(.WIDTH(8), .CNT_W(4), .SAT(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid),
    .d(d), .sub(sub), .out(out1), .busy(busy1), .done(done1), .ovf(ovf1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks out/busy/done/ovf of one instance (0 = wrap, 1 = saturate).
  task automatic chk4(input string tag, input int which, input logic [7:0] eo,
                      input logic eb, input logic ed, input logic ev);
    if (which == 0) begin
      chk({tag, ".u0.out"}, out0, eo);
      chk({tag, ".u0.busy"}, {7'd0, busy0}, {7'd0, eb});
      chk({tag, ".u0.done"}, {7'd0, done0}, {7'd0, ed});
      chk({tag, ".u0.ovf"}, {7'd0, ovf0}, {7'd0, ev});
    end else begin
      chk({tag, ".u1.out"}, out1, eo);
      chk({tag, ".u1.busy"}, {7'd0, busy1}, {7'd0, eb});
      chk({tag, ".u1.done"}, {7'd0, done1}, {7'd0, ed});
      chk({tag, ".u1.ovf"}, {7'd0, ovf1}, {7'd0, ev});
    end
  endtask

  task automatic chkb(input string tag, input logic [7:0] eo,
                      input logic eb, input logic ed, input logic ev);
    chk4(tag, 0, eo, eb, ed, ev);
    chk4(tag, 1, eo, eb, ed, ev);
  endtask

  initial begin
    // reset with start and in_valid both asserted
    rst_n = 1'b0; start = 1'b1; len = 4'd3; in_valid = 1'b1; d = 8'd5; sub = 1'b0;
    tick(); chkb("rst1", 8'd0, 0, 0, 0);
    tick(); chkb("rst2", 8'd0, 0, 0, 0);
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
    tick(); chkb("rst_rel", 8'd0, 0, 0, 0);

    // basic run: +5 +10 -3
    start = 1'b1; len = 4'd3;
    tick(); chkb("basic_start", 8'd0, 1, 0, 0);
    start = 1'b0; in_valid = 1'b1; d = 8'd5; sub = 1'b0;
    tick(); chkb("basic_b1", 8'd5, 1, 0, 0);
    d = 8'd10;
    tick(); chkb("basic_b2", 8'd15, 1, 0, 0);
    d = 8'd3; sub = 1'b1;
    tick(); chkb("basic_b3", 8'd12, 0, 1, 0);
    in_valid = 1'b0; sub = 1'b0;
    tick(); chkb("basic_hold", 8'd12, 0, 0, 0);
    in_valid = 1'b1; d = 8'd50;
    tick(); chkb("idle_ignore", 8'd12, 0, 0, 0);
    in_valid = 1'b0;

    // gapped beats, then an empty run
    start = 1'b1; len = 4'd2;
    tick(); chkb("gap_start", 8'd0, 1, 0, 0);
    start = 1'b0; in_valid = 1'b1; d = 8'd7;
    tick(); chkb("gap_b1", 8'd7, 1, 0, 0);
    in_valid = 1'b0;
    tick(); tick(); tick(); chkb("gap_wait", 8'd7, 1, 0, 0);
    in_valid = 1'b1; d = 8'd8;
    tick(); chkb("gap_b2", 8'd15, 0, 1, 0);
    in_valid = 1'b0; start = 1'b1; len = 4'd0;
    tick(); chkb("empty_run", 8'd0, 0, 1, 0);
    start = 1'b0;
    tick(); chkb("empty_after", 8'd0, 0, 0, 0);

    // overflow: +100 +100
    start = 1'b1; len = 4'd2;
    tick(); start = 1'b0; in_valid = 1'b1; d = 8'd100; sub = 1'b0;
    tick(); chkb("ovf_b1", 8'd100, 1, 0, 0);
    tick();
    chk4("ovf_add", 0, 8'hC8, 0, 1, 1);
    chk4("ovf_add", 1, 8'h7F, 0, 1, 1);
    in_valid = 1'b0; start = 1'b1; len = 4'd2;
    tick(); chkb("ovf_clear", 8'd0, 1, 0, 0);

    // negative overflow: 0 - 100 - 100
    start = 1'b0; in_valid = 1'b1; d = 8'd100; sub = 1'b1;
    tick(); chkb("neg_b1", 8'h9C, 1, 0, 0);
    tick();
    chk4("neg_ovf", 0, 8'h38, 0, 1, 1);
    chk4("neg_ovf", 1, 8'h80, 0, 1, 1);
    in_valid = 1'b0; sub = 1'b0;
    tick(); chk4("ovf_hold", 1, 8'h80, 0, 0, 1);

    // abort and restart
    start = 1'b1; len = 4'd4;
    tick(); start = 1'b0; in_valid = 1'b1; d = 8'd1;
    tick(); chkb("ab_b1", 8'd1, 1, 0, 0);
    tick(); chkb("ab_b2", 8'd2, 1, 0, 0);
    start = 1'b1; len = 4'd1;
    tick(); chkb("ab_restart", 8'd0, 1, 0, 0);
    start = 1'b0; d = 8'd9;
    tick(); chkb("ab_b9", 8'd9, 0, 1, 0);
    in_valid = 1'b0;
    tick(); chkb("ab_after", 8'd9, 0, 0, 0);

    // reset mid-run after an overflow
    start = 1'b1; len = 4'd5;
    tick(); start = 1'b0; in_valid = 1'b1; d = 8'd100;
    tick(); tick(); tick();
    chk4("mid_pre", 0, 8'h2C, 1, 0, 1);
    chk4("mid_pre", 1, 8'h7F, 1, 0, 1);
    rst_n = 1'b0;
    tick(); chkb("mid_rst", 8'd0, 0, 0, 0);
    rst_n = 1'b1; d = 8'd5;
    tick(); chkb("post_rst1", 8'd0, 0, 0, 0);
    tick(); chkb("post_rst2", 8'd0, 0, 0, 0);
    in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
